// File: rtl/core_pkg.sv
// Shared constants for the integer register file: bank geometry, pointer
// indices and default reset presets for sp/gp.
package core_pkg;

    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int SP_INDEX   = 2;
    localparam int GP_INDEX   = 3;

    localparam logic [DATA_W-1:0] SP_INIT_DEFAULT = 32'h7FFF_EFFC;
    localparam logic [DATA_W-1:0] GP_INIT_DEFAULT = 32'h1000_8000;

endpackage

// File: rtl/write_decoder.sv
// One-hot write-enable decoder for the register bank, gated by reg_write.
// x0 has no storage, so its enable is never asserted.
module write_decoder
    import core_pkg::*;
(
    input  logic                  reg_write_i,
    input  logic [REG_ADDR_W-1:0] addr_i,
    output logic [NUM_REGS-1:0]   we_o
);

    always_comb begin
        we_o = '0;
        if (reg_write_i) begin
            we_o[addr_i] = 1'b1;
        end
        we_o[0] = 1'b0;
    end

endmodule

// File: rtl/register_file.sv
// 32 x N architectural register file: one write port, two combinational read
// ports with same-cycle write bypass, x0 hardwired to zero, sp/gp preset on reset.
module register_file
    import core_pkg::*;
#(
    parameter int                N       = DATA_W,
    parameter logic [N-1:0]      SP_INIT = SP_INIT_DEFAULT,
    parameter logic [N-1:0]      GP_INIT = GP_INIT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reg_write,
    input  logic [REG_ADDR_W-1:0] write_register,
    input  logic [N-1:0]          write_data,
    input  logic [REG_ADDR_W-1:0] read_register_1,
    input  logic [REG_ADDR_W-1:0] read_register_2,
    output logic [N-1:0]          read_data_1,
    output logic [N-1:0]          read_data_2
);

    logic [NUM_REGS-1:0] we;
    logic [N-1:0]        words [NUM_REGS];

    write_decoder u_write_decoder (
        .reg_write_i (reg_write),
        .addr_i      (write_register),
        .we_o        (we)
    );

    assign words[0] = '0;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_word
        localparam logic [N-1:0] RST_VAL = (i == SP_INDEX) ? SP_INIT :
                                           (i == GP_INDEX) ? GP_INIT : '0;
        logic [N-1:0] word_q;
        logic [N-1:0] word_d;

        always_comb begin
            word_d = word_q;
            if (we[i]) begin
                word_d = write_data;
            end
        end

        // Reset wins over a write sampled on the same edge.
        always_ff @(posedge clk) begin
            if (!reset) begin
                word_q <= RST_VAL;
            end else begin
                word_q <= word_d;
            end
        end

        assign words[i] = word_q;
    end

    // The decoded enable already excludes x0, so a hit implies a nonzero address;
    // gating with reset keeps write_data off the outputs while reset is low.
    logic hit_1;
    logic hit_2;

    always_comb begin
        hit_1       = reset & we[read_register_1];
        hit_2       = reset & we[read_register_2];
        read_data_1 = hit_1 ? write_data : words[read_register_1];
        read_data_2 = hit_2 ? write_data : words[read_register_2];
    end

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus pushes expected read values,
// a negedge monitor pops and compares them against both read ports.
module tb_register_file;

    logic        clk;
    logic        reset;
    logic        reg_write;
    logic [4:0]  write_register;
    logic [31:0] write_data;
    logic [4:0]  read_register_1;
    logic [4:0]  read_register_2;
    logic [31:0] read_data_1;
    logic [31:0] read_data_2;

    localparam logic [31:0] SP = 32'h7FFF_EFFC;
    localparam logic [31:0] GP = 32'h1000_8000;

    typedef struct {
        logic [31:0] e1;
        logic [31:0] e2;
        string       tag;
    } exp_t;

    exp_t sb_q[$];
    logic chk_valid;
    int   checks;
    int   failures;

    register_file dut (
        .clk             (clk),
        .reset           (reset),
        .reg_write       (reg_write),
        .write_register  (write_register),
        .write_data      (write_data),
        .read_register_1 (read_register_1),
        .read_register_2 (read_register_2),
        .read_data_1     (read_data_1),
        .read_data_2     (read_data_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] preset(int idx);
        if (idx == 2) return SP;
        if (idx == 3) return GP;
        return 32'h0;
    endfunction

    always @(negedge clk) begin
        if (chk_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty: output presented with no expected entry");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checks++;
                if (read_data_1 !== e.e1) begin
                    failures++;
                    $display("FAIL %s rd1: got %h expected %h", e.tag, read_data_1, e.e1);
                end
                checks++;
                if (read_data_2 !== e.e2) begin
                    failures++;
                    $display("FAIL %s rd2: got %h expected %h", e.tag, read_data_2, e.e2);
                end
            end
        end
    end

    // One call occupies one clock cycle; any write commits at the edge ending it.
    task automatic apply(input logic rst, input logic we, input logic [4:0] rd,
                         input logic [31:0] wd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] x1,
                         input logic [31:0] x2, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        reset           = rst;
        reg_write       = we;
        write_register  = rd;
        write_data      = wd;
        read_register_1 = rs1;
        read_register_2 = rs2;
        e.e1  = x1;
        e.e2  = x2;
        e.tag = tag;
        sb_q.push_back(e);
        chk_valid = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks          = 0;
        failures        = 0;
        chk_valid       = 1'b0;
        reset           = 1'b0;
        reg_write       = 1'b0;
        write_register  = 5'd0;
        write_data      = 32'h0;
        read_register_1 = 5'd0;
        read_register_2 = 5'd0;

        apply(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd1, 32'h0, 32'h0, "reset_a");
        apply(1'b0, 1'b0, 5'd0, 32'h0, 5'd2, 5'd3, SP, GP, "reset_b");

        for (int i = 0; i < 32; i++) begin
            apply(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i),
                  preset(i), preset(31 - i), "reset_sweep");
        end

        apply(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd6, 32'hDEAD_BEEF, 32'h0, "wr_x5_bypass");
        apply(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd6, 32'hDEAD_BEEF, 32'h0, "rd_x5_stored");

        apply(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 32'h0, 32'h0, "wr_x0_same");
        apply(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, "wr_x0_next");

        apply(1'b1, 1'b0, 5'd7, 32'h1234_5678, 5'd7, 5'd7, 32'h0, 32'h0, "no_we_no_bypass");
        apply(1'b1, 1'b1, 5'd7, 32'h1234_5678, 5'd7, 5'd7, 32'h1234_5678, 32'h1234_5678, "bypass_both");
        apply(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd5, 32'h1234_5678, 32'hDEAD_BEEF, "x7_stored");

        apply(1'b0, 1'b1, 5'd2, 32'hAAAA_AAAA, 5'd2, 5'd2, SP, SP, "wr_in_reset");
        apply(1'b1, 1'b0, 5'd0, 32'h0, 5'd2, 5'd5, SP, 32'h0, "after_reset_wr");
        apply(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd3, 32'h0, GP, "after_reset_x7");

        for (int i = 1; i < 32; i++) begin
            apply(1'b1, 1'b1, 5'(i), 32'(i), 5'(i), 5'(i - 1),
                  32'(i), 32'(i - 1), "fill");
        end

        apply(1'b0, 1'b1, 5'd9, 32'hFFFF_0000, 5'd9, 5'd2, 32'd9, 32'd2, "reset_pulse");
        apply(1'b1, 1'b1, 5'd4, 32'hCAFE_F00D, 5'd4, 5'd2, 32'hCAFE_F00D, SP, "first_wr_after");

        for (int i = 0; i < 32; i++) begin
            apply(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i),
                  (i == 4) ? 32'hCAFE_F00D : preset(i),
                  (31 - i == 4) ? 32'hCAFE_F00D : preset(31 - i), "post_pulse_sweep");
        end

        @(posedge clk);
        #1;
        chk_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
